iec_sd_arb: RTL

- Arbitrates sector read/write requests from NDRIVES IEC drive selector instances onto the single host SD block channel.
- Sits between the drive instances and the host I/O block. All logic runs in the clk_sys domain.
- Grants one drive at a time, round-robin, and latches its LBA and operation.
- Routes the host ack, buffer write strobe and buffer readback to and from the granted drive only.

---
 rtl/iec_sd_pkg.sv | 25 ++
 rtl/iec_sd_arb_rr_pick.sv | 27 ++
 rtl/iec_sd_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/iec_sd_pkg.sv
// Shared types and constants for the IEC drive SD-channel arbiter.
package iec_sd_pkg;

  localparam int GW = 2;
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd12000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Round-robin successor of index g among n requesters.
  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g, input int n);
    if (int'(g) >= n - 1) return '0;
    else return g + 1'b1;
  endfunction

endpackage

// File: rtl/iec_sd_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          valid
);

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    logic [GW-1:0] c;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c = GW'((int'(ptr) + i) % N);
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/iec_sd_arb.sv
// Arbitrates per-drive sector requests onto the single host SD block channel.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | searching pending requests from the round-robin pointer
// REQ     | host request asserted, waiting for ack / abort / timeout
// XFER    | host ack high, strobe and readback routed to granted drive
// RELEASE | one cycle after ack falls, pointer moves past the grant
module iec_sd_arb
  import iec_sd_pkg::*;
#(
  parameter int          NDRIVES = 4,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NDRIVES*32-1:0]   drv_lba,
  input  logic [NDRIVES-1:0]      drv_rd,
  input  logic [NDRIVES-1:0]      drv_wr,
  output logic [NDRIVES-1:0]      drv_ack,
  output logic [NDRIVES-1:0]      drv_buff_wr,
  input  logic [NDRIVES*8-1:0]    drv_buff_din,
  output logic [31:0]             sd_lba,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  input  logic                    sd_buff_wr,
  output logic [7:0]              sd_buff_din,
  output logic                    busy,
  output logic [GW-1:0]           grant,
  output logic                    timeout_err
);

  state_t        state, state_nxt;
  op_t           op, op_nxt;
  logic [GW-1:0] ptr, ptr_nxt, grant_nxt;
  logic [31:0]   lba_nxt;
  logic [23:0]   cnt, cnt_nxt;
  logic          rd_nxt, wr_nxt, terr_nxt;
  logic [GW-1:0] pick_idx;
  logic          pick_valid;
  logic          timeout_hit;

  logic [31:0] lba_arr [NDRIVES];
  logic [7:0]  din_arr [NDRIVES];

  for (genvar i = 0; i < NDRIVES; i++) begin : g_unpack
    assign lba_arr[i] = drv_lba[32*i +: 32];
    assign din_arr[i] = drv_buff_din[8*i +: 8];
  end

  rr_pick #(.N(NDRIVES), .GW(GW)) u_pick (
    .req   (drv_rd | drv_wr),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Widened so a counter at all-ones cannot wrap past the limit.
  assign timeout_hit = ({1'b0, cnt} + 25'd1) >= {1'b0, TIMEOUT};
  assign busy        = (state != ST_IDLE);

  // State and registered host-side outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= ST_IDLE;
      op          <= OP_READ;
      ptr         <= '0;
      grant       <= '0;
      sd_lba      <= '0;
      cnt         <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      op          <= op_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      sd_lba      <= lba_nxt;
      cnt         <= cnt_nxt;
      sd_rd       <= rd_nxt;
      sd_wr       <= wr_nxt;
      timeout_err <= terr_nxt;
    end
  end

  // Next-state logic; host request lines default low so every exit from REQ drops them.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    lba_nxt   = sd_lba;
    cnt_nxt   = cnt;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    terr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_idx;
          lba_nxt   = lba_arr[pick_idx];
          op_nxt    = drv_wr[pick_idx] ? OP_WRITE : OP_READ;
          cnt_nxt   = '0;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          state_nxt = ST_XFER;
        end else if (!(drv_rd[grant] || drv_wr[grant])) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = next_ptr(grant, NDRIVES);
        end else if (timeout_hit) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = next_ptr(grant, NDRIVES);
          terr_nxt  = 1'b1;
        end else begin
          rd_nxt = (op == OP_READ);
          wr_nxt = (op == OP_WRITE);
          if (cnt != '1) cnt_nxt = cnt + 24'd1;
        end
      end
      ST_XFER: begin
        if (!sd_ack) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        ptr_nxt   = next_ptr(grant, NDRIVES);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drive-side routing: only the granted drive sees ack, strobe and readback.
  always_comb begin
    drv_ack     = '0;
    drv_buff_wr = '0;
    sd_buff_din = '0;
    if (state == ST_REQ || state == ST_XFER) drv_ack[grant] = sd_ack;
    if (state == ST_XFER) begin
      drv_buff_wr[grant] = sd_buff_wr;
      sd_buff_din        = din_arr[grant];
    end
  end

endmodule
